// File: rtl/dilate_stream.sv
// Streaming binary dilation over a Width x Height neighbourhood of a raster pixel stream.
// Latency: one cycle from accepted input pixel to out_valid/out_pixel.
// Backpressure: none; one pixel per cycle in, one per cycle out, consumer must always accept.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   element          - structuring element, bit i*Width+j selects neighbour (row-i, col-j);
//                      latched on accepted sof pixels and on the first edge after reset
//   in_valid/in_sof  - input strobe and start-of-frame marker (pixel (0,0))
//   in_pixel         - binary input pixel
//   out_valid        - in_valid delayed one cycle
//   out_pixel        - dilated pixel, holds its value while out_valid is low
module dilate_stream #(
  parameter int Width      = 3,
  parameter int Height     = 3,
  parameter int ImageWidth = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [Width*Height-1:0]   element,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic                      in_pixel,
  output logic                      out_valid,
  output logic                      out_pixel
);

  // Neighbour (r-i, c-j) lives at tap i*ImageWidth+j once the current pixel is
  // shifted in. Tap 0 is the live input, so only the older taps need storage.
  localparam int HistLen  = (Height - 1) * ImageWidth + Width;
  localparam int StoreLen = (HistLen > 1) ? HistLen - 1 : 1;
  localparam int ColW     = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int RowW     = (Height > 1) ? $clog2(Height) : 1;

  logic [StoreLen-1:0]     hist_q, hist_d;
  logic [ColW-1:0]         col_q, col_d, col_cur;
  logic [RowW-1:0]         row_q, row_d, row_cur;
  logic [Width*Height-1:0] elem_q, elem_d;
  logic                    latch_pend_q;
  logic                    out_valid_q;
  logic                    out_pixel_q;
  logic                    hit;
  logic [StoreLen:0]       taps;

  assign taps = {hist_q, in_pixel};

  always_comb begin
    // A new element takes effect on the very pixel that latches it.
    elem_d  = (latch_pend_q || (in_valid && in_sof)) ? element : elem_q;

    // An sof pixel is (0,0) whatever the counters say.
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;

    hit = 1'b0;
    for (int i = 0; i < Height; i++) begin
      for (int j = 0; j < Width; j++) begin
        // Mask taps above the frame top and left of column 0 (no row wrap).
        if (i <= int'(row_cur) && j <= int'(col_cur)) begin
          hit = hit | (elem_d[i*Width+j] & taps[i*ImageWidth+j]);
        end
      end
    end

    hist_d[0] = in_pixel;
    for (int k = 1; k < StoreLen; k++) begin
      hist_d[k] = hist_q[k-1];
    end

    if (col_cur == ColW'(ImageWidth - 1)) begin
      col_d = '0;
      // Only "row >= i" matters, so the row count saturates at Height-1.
      row_d = (row_cur == RowW'(Height - 1)) ? row_cur : row_cur + RowW'(1);
    end else begin
      col_d = col_cur + ColW'(1);
      row_d = row_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      elem_q       <= '0;
      latch_pend_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= 1'b0;
    end else begin
      latch_pend_q <= 1'b0;
      elem_q       <= elem_d;
      out_valid_q  <= in_valid;
      if (in_valid) begin
        hist_q      <= hist_d;
        col_q       <= col_d;
        row_q       <= row_d;
        out_pixel_q <= hit;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_dilate_stream.sv
// Bench for dilate_stream (3x3 element, 4-pixel rows): positional reference
// model plus literal expectations for hand-worked frames.
module tb_dilate_stream;
  localparam int W  = 3;
  localparam int H  = 3;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [W*H-1:0] element;
  logic           in_valid;
  logic           in_sof;
  logic           in_pixel;
  logic           out_valid;
  logic           out_pixel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dilate_stream #(.Width(W), .Height(H), .ImageWidth(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .element  (element),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
    .out_valid(out_valid),
    .out_pixel(out_pixel)
  );

  // Reference model: pixels of the current frame stored by (row, col),
  // output computed directly from the dilation definition.
  int             m_row, m_col;
  bit [W*H-1:0]   m_elem;
  bit             m_pend;
  bit             pix [int];
  bit             exp_vld = 1'b0;
  bit             exp_pix = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_vld = 1'b0;
      exp_pix = 1'b0;
      pix.delete();
      m_row   = 0;
      m_col   = 0;
      m_elem  = '0;
      m_pend  = 1'b1;
    end else begin
      if (m_pend || (in_valid && in_sof)) m_elem = element;
      m_pend  = 1'b0;
      exp_vld = in_valid;
      if (in_valid) begin
        if (in_sof) begin
          m_row = 0;
          m_col = 0;
          pix.delete();
        end
        pix[m_row*IW + m_col] = in_pixel;
        exp_pix = 1'b0;
        for (int i = 0; i < H; i++) begin
          for (int j = 0; j < W; j++) begin
            if (m_row - i >= 0 && m_col - j >= 0 && m_elem[i*W+j]) begin
              if (pix.exists((m_row-i)*IW + m_col - j) && pix[(m_row-i)*IW + m_col - j])
                exp_pix = 1'b1;
            end
          end
        end
        m_col++;
        if (m_col == IW) begin
          m_col = 0;
          m_row++;
        end
      end
    end
  end

  // Per-cycle compare against the model; also collect emitted pixels.
  bit out_q [$];

  always @(negedge clk) begin
    checks++;
    if (out_valid !== exp_vld) begin
      errors++;
      $display("FAIL out_valid at %0t: got %b want %b", $time, out_valid, exp_vld);
    end
    checks++;
    if (out_pixel !== exp_pix) begin
      errors++;
      $display("FAIL out_pixel at %0t: got %b want %b", $time, out_pixel, exp_pix);
    end
    if (out_valid === 1'b1) out_q.push_back(out_pixel);
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic px(input bit v, input bit s, input bit p);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
  endtask

  // Sends one 4x4 frame (bit r*4+c is pixel (r,c)) and checks the collected
  // outputs against a hand-computed image.
  task automatic frame(input string name, input logic [15:0] img, input logic [8:0] el,
                       input logic [8:0] el_late, input int switch_at, input int gap_pct,
                       input bit use_sof, input logic [15:0] want);
    logic [15:0] got;
    out_q.delete();
    for (int k = 0; k < 16; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) px(1'b0, 1'b0, 1'($urandom_range(1)));
      element = (k >= switch_at) ? el_late : el;
      px(1'b1, use_sof && (k == 0), img[k]);
    end
    px(1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b0);
    #1;
    got = '0;
    for (int k = 0; k < 16 && k < out_q.size(); k++) got[k] = out_q[k];
    lit({name, "_count"}, 16'(out_q.size()), 16'd16);
    lit(name, got, want);
  endtask

  logic [15:0] rnd;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_pixel = 1'b1;
    element  = 9'h1FF;
    repeat (2) begin
      @(negedge clk);
      lit("rst_out_valid", 16'(out_valid), 16'd0);
      lit("rst_out_pixel", 16'(out_pixel), 16'd0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;

    // First pixel after release is (0,0) even without sof.
    frame("post_reset_origin", 16'h0001, 9'h1FF, 9'h1FF, 99, 0, 1'b0, 16'h0777);
    frame("single_origin",     16'h0001, 9'h1FF, 9'h1FF, 99, 0, 1'b1, 16'h0777);
    frame("single_col3",       16'h0008, 9'h1FF, 9'h1FF, 99, 0, 1'b1, 16'h0888);

    rnd = 16'($urandom);
    frame("identity_gaps",     rnd,      9'h001, 9'h001, 99, 40, 1'b1, rnd);
    frame("all_ones",          16'hFFFF, 9'h1FF, 9'h1FF, 99, 0, 1'b1, 16'hFFFF);
    frame("zeros_after_ones",  16'h0000, 9'h1FF, 9'h1FF, 99, 0, 1'b1, 16'h0000);

    // Element changed mid-frame only takes effect at the next sof.
    rnd = 16'($urandom);
    frame("elem_change_mid",   rnd,      9'h001, 9'h1FF, 5, 20, 1'b1, rnd);
    frame("elem_after_sof",    16'h0001, 9'h1FF, 9'h1FF, 99, 0, 1'b1, 16'h0777);

    // Reset asserted while pixel (2,1) is presented.
    element = 9'h1FF;
    for (int k = 0; k < 9; k++) px(1'b1, k == 0, 1'b1);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_pixel = 1'b1;
    @(negedge clk);
    #1;
    lit("midrst_out_valid", 16'(out_valid), 16'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    frame("after_midrst",      16'h0008, 9'h1FF, 9'h1FF, 99, 0, 1'b1, 16'h0888);

    // Randomised traffic: gaps, sparse pixels, sof anywhere, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset    = ($urandom_range(299) == 0);
      in_valid = ($urandom_range(99) < 70);
      in_sof   = ($urandom_range(24) == 0);
      in_pixel = ($urandom_range(99) < 20);
      element  = 9'($urandom);
    end
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (3) @(negedge clk);
    frame("final_frame",       16'h0001, 9'h1FF, 9'h1FF, 99, 0, 1'b1, 16'h0777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dilate_stream.md
# dilate_stream

Streaming binary morphological dilation unit for the morphology datapath: the dilation counterpart to the erosion node, operating on a raster pixel stream instead of a pre-assembled window. It holds the last `Height` image rows in an internal delay line, assembles a `Width`×`Height` neighbourhood around every accepted pixel, and emits one dilated pixel per input pixel. Its output feeds the same downstream consumers as the erosion path, so erode/dilate pairs can be chained into open/close pipelines.

## Interface
- `Width`, 3, structuring-element columns (≥1)
- `Height`, 3, structuring-element rows (≥1)
- `ImageWidth`, 16, pixels per image row (≥ `Width`)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `element`  in  `Width*Height`  structuring element; bit `i*Width+j` selects neighbour (row−i, col−j)
- `in_valid`  in  1  input pixel strobe
- `in_sof`  in  1  start of frame, qualified by `in_valid`; marks the pixel at (0,0)
- `in_pixel`  in  1  binary input pixel
- `out_valid`  out  1  output pixel strobe
- `out_pixel`  out  1  dilated pixel

## Operation
- One clock domain, `clk`. Reset is synchronous and active-high.
- Accepted pixel = `in_valid`=1 on a rising edge. Cycles with `in_valid`=0 leave all state unchanged (no gaps are inserted into the history).
- Position counters:
  - `col` runs 0..`ImageWidth`−1 and wraps to 0, incrementing `row`.
  - `row` saturates at `Height`−1; only the comparison against `i` is needed.
- An accepted pixel with `in_sof`=1 is position (0,0), regardless of the current counters. The next accepted pixel is (0,1).
- History: shift register of length `(Height−1)*ImageWidth + Width`. The accepted pixel is shifted in at index 0, so neighbour (r−i, c−j) sits at index `i*ImageWidth+j`.
- `element` is latched on every accepted `in_sof` pixel and on reset release. It is ignored at all other times. After reset, the latch holds the value present on the first clock edge with `reset`=0.
- Window bit (i,j):
  - Value is the history pixel, or the current `in_pixel` for (0,0).
  - Forced to 0 when `i` > `row` (above the frame).
  - Forced to 0 when `j` > `col` (no wrap into the previous row).
- `out_pixel` = OR over all (i,j) of (latched element bit AND masked window bit).
- Anchor: the output for input (r,c) is the dilation whose window bottom-right corner is (r,c). The image is therefore shifted by ((Height−1)/2, (Width−1)/2) relative to a centred kernel; downstream blocks compensate.
- An all-zero element gives `out_pixel`=0 always.
- The sof mask (`row`=0) prevents pixels from the previous frame reaching the new frame's output. The history itself is not cleared.

## Timing
- Reset values:
  - `out_valid`=0, `out_pixel`=0
  - `col`=0, `row`=0
  - history all 0
  - latched element all 0
- Latency: 1 cycle. `out_valid` is `in_valid` registered. `out_pixel` is registered in the same edge from the window that includes the current `in_pixel`.
- Throughput: 1 pixel/cycle, no backpressure. The consumer must accept every `out_valid` pulse.
- `out_pixel` holds its last value while `out_valid`=0.
- Reset mid-frame: the next cycle shows `out_valid`=0. An in-flight output is dropped. The next accepted pixel without `in_sof` is treated as (0,0).
- `in_sof` at `col`≠0: the frame restarts at once and the partial row is discarded.

## Test plan
(W=H=3, ImageWidth=4, 4×4 frames, sof on first pixel.)
- Reset held 2 cycles with `in_valid`=1 → `out_valid`=0 and `out_pixel`=0 throughout. The first accepted pixel after release is (0,0).
- Single 1 at (0,0), element=9'h1FF → outputs 1 exactly at (r,c) with r,c ∈ {0,1,2}, 0 at all other 7 positions. Each output appears 1 cycle after its input.
- Single 1 at (0,3), element=9'h1FF → (1,3),(2,3)=1. (1,0),(1,1),(2,0),(3,0)=0, so no column wrap.
- element=9'h001, random pixels with random `in_valid` gaps → `out_pixel` equals `in_pixel` delayed one accepted pixel, and the `out_valid` pattern equals the `in_valid` pattern delayed 1 cycle.
- Frame of all 1s, then new sof with all 0s, element=9'h1FF → every output of the second frame is 0 (no leakage across sof).
- element changed mid-frame → output uses the old element until the next sof. Reset asserted at pixel (2,1) → `out_valid`=0 on the next cycle, and a following clean frame matches the golden model.
